// File: rtl/event_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | event_pkg: handshake FSM states and lowest-set-bit priority pick |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package event_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  localparam int c_MAX_W = 16;

  // Scans from the top down so the lowest set index is the last one written.
  function automatic logic [3:0] lowest_set(input logic [c_MAX_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = c_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter: accumulating counter that sticks at its maximum     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 8,
  parameter int INC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam int c_SUM_W = CNT_W + INC_W + 1;
  localparam logic [c_SUM_W-1:0] c_MAX = {{(INC_W + 1){1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0]   r_count;
  logic [c_SUM_W-1:0] w_sum;

  // Sum is computed wide enough that it can never wrap before the compare.
  always_comb begin
    w_sum = {{(INC_W + 1){1'b0}}, r_count} + {{(CNT_W + 1){1'b0}}, i_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_sum > c_MAX) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/event_or_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | event_or_collector: sticky edge latch, masked irq, id handshake  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module event_or_collector
  import event_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         i_req,
  input  logic [WIDTH-1:0]         i_mask,
  input  logic                     i_ack,
  output logic [WIDTH-1:0]         o_pending,
  output logic                     o_irq,
  output logic                     o_valid,
  output logic [$clog2(WIDTH)-1:0] o_id,
  output logic [CNT_W-1:0]         o_dropped
);

  localparam int c_ID_W  = $clog2(WIDTH);
  localparam int c_INC_W = $clog2(WIDTH + 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_req_q;
  logic [WIDTH-1:0]     r_pending;
  logic                 r_irq;
  logic                 r_valid;
  logic [c_ID_W-1:0]    r_id;

  logic [WIDTH-1:0]     w_edge;
  logic [WIDTH-1:0]     w_clr;
  logic [WIDTH-1:0]     w_drop;
  logic [WIDTH-1:0]     w_masked;
  logic [c_MAX_W-1:0]   w_masked_ext;
  logic [c_ID_W-1:0]    w_id;
  logic [c_INC_W-1:0]   w_drop_cnt;

  always_comb begin
    w_edge = i_req & ~r_req_q;
    w_clr  = '0;
    if (r_state == S_PRESENT && i_ack) begin
      w_clr[r_id] = 1'b1;
    end
    // A same-cycle clear frees the slot, so that edge is not a loss.
    w_drop       = w_edge & r_pending & ~w_clr;
    w_masked     = r_pending & i_mask;
    w_masked_ext = '0;
    w_masked_ext[WIDTH-1:0] = w_masked;
    w_id         = c_ID_W'(lowest_set(w_masked_ext));
    w_drop_cnt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_drop_cnt = w_drop_cnt + c_INC_W'(w_drop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
      r_irq     <= 1'b0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_state   <= S_IDLE;
    end else begin
      r_req_q   <= i_req;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_irq     <= |w_masked;
      case (r_state)
        S_IDLE: begin
          // irq lags one cycle, so re-qualify against the live masked view.
          if (r_irq && (|w_masked)) begin
            r_id    <= w_id;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (i_ack) begin
            r_valid <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (c_INC_W)
  ) u_dropped (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_drop_cnt),
    .o_count (o_dropped)
  );

  assign o_pending = r_pending;
  assign o_irq     = r_irq;
  assign o_valid   = r_valid;
  assign o_id      = r_id;

endmodule
`default_nettype wire

// File: doc/event_or_collector.md
EVENT_OR_COLLECTOR -- requirements
Module: event_or_collector

Interface
REQ-001 Parameter WIDTH, default 4, gives the number of request lines (2..16).
REQ-002 Parameter CNT_W, default 8, gives the width of the dropped-event counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  WIDTH  level request lines, synchronous to clk.
REQ-006 mask  input  WIDTH  1 = line enabled for reporting.
REQ-007 ack  input  1  consumer accepts the presented event.
REQ-008 pending  output  WIDTH  sticky latched events, unmasked view.
REQ-009 irq  output  1  registered OR of (pending AND mask).
REQ-010 valid  output  1  an event id is presented.
REQ-011 id  output  $clog2(WIDTH)  index of presented event.
REQ-012 dropped  output  CNT_W  saturating count of lost events.

Function
REQ-013 The block SHALL register req each cycle and detect rising edges as req AND NOT req_q.
REQ-014 A rising edge on line i SHALL set pending[i] on the next clk edge, regardless of mask.
REQ-015 irq SHALL equal the OR-reduction of (pending AND mask) delayed by one register stage; an edge sampled in cycle N gives irq=1 in cycle N+2.
REQ-016 The FSM SHALL have the states IDLE, PRESENT and GAP.
REQ-017 IDLE: valid=0. When irq=1, the FSM SHALL latch id as the lowest-index masked pending bit and go to PRESENT.
REQ-018 PRESENT: valid=1 and id SHALL stay stable until ack=1 is sampled.
REQ-019 On ack in PRESENT, the FSM SHALL clear pending[id] and go to GAP.
REQ-020 GAP: valid=0 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-021 Back-to-back events SHALL therefore be presented no faster than one every 3 cycles.
REQ-022 ack while valid=0 SHALL be ignored, with no state change.
REQ-023 If mask[id] drops during PRESENT, the event SHALL still be presented until it is acknowledged.
REQ-024 If an edge on line i and a clear of bit i occur in the same cycle, set SHALL win and pending[i] SHALL remain 1.
REQ-025 An edge on line i while pending[i]=1 (and not being cleared that cycle) SHALL increment dropped by 1.
REQ-026 Multiple simultaneous drops in one cycle SHALL add their popcount.
REQ-027 dropped SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 Masked lines SHALL still latch into pending and SHALL be reported once they are unmasked.

Reset
REQ-029 When rst=1 at a clk edge: pending=0, req_q=0, irq=0, valid=0, id=0, dropped=0, FSM=IDLE.
REQ-030 Reset asserted mid-handshake (PRESENT or GAP) SHALL abandon the event with no clear side effects beyond REQ-029.
REQ-031 Because req_q resets to 0, a req line held high through reset release SHALL register one edge in the first cycle after reset.

Structure
REQ-032 The FSM state encoding and a lowest-set-bit priority function SHALL live in shared package event_pkg.
REQ-033 The dropped-event counter SHALL be a sub-module sat_counter with parameter CNT_W, an increment amount input and synchronous reset.
REQ-034 All outputs SHALL be driven directly from registers.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset, then req=4'b0100 held with mask=4'hF -> pending=0100 one cycle later, irq=1 two cycles later, valid=1 with id=2; ack -> pending=0, valid=0 in GAP.
- req edges on lines 1 and 3 together, mask=4'hF -> id=1 presented first; after ack and GAP, id=3 presented.
- Line 0 pulsed twice before any ack -> pending[0]=1 and dropped=1.
- Line 2 pulsed in the same cycle that ack clears id=2 -> pending[2]=1 and dropped unchanged.
- mask=4'b0000 with a line-1 edge -> pending=0010 and irq=0; set mask=4'b0010 -> irq=1 after one cycle.
- CNT_W=2 with 5 drops on one line -> dropped=3; rst asserted while valid=1 -> all outputs 0 on the next cycle.
